// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage exponent compare and mantissa alignment; define FP_ALIGN_STICKY_EN for sticky and LSB jamming
module fp_align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int GRD_W = 9,
    localparam int W = MAN_W + 1 + GRD_W,
    localparam int SH_W = $clog2(W + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] a_op,
    input  logic [EXP_W+MAN_W-1:0] b_op,
    input  logic                   a_hid,
    input  logic                   b_hid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           big_man,
    output logic [W-1:0]           small_man,
    output logic [EXP_W-1:0]       big_exp,
    output logic                   swapped,
    output logic                   sticky
);
    logic [MAN_W:0] a_sig, b_sig, s1_big_q, s1_big_d, s1_small_q, s1_small_d;
    logic [EXP_W-1:0] a_exp, b_exp, s1_exp_q, s1_exp_d, big_exp_q, big_exp_d;
    logic [EXP_W:0] d, mag;
    logic [SH_W-1:0] sh, s1_sh_q, s1_sh_d;
    logic [W-1:0] shifted, big_man_q, big_man_d, small_man_q, small_man_d;
    logic s1_v_q, s1_v_d, s1_swp_q, s1_swp_d;
    logic out_valid_q, out_valid_d, swapped_q, swapped_d, sticky_q, sticky_d;
    logic s2_ready, s1_ld, s2_ld, stk;

    assign a_exp = a_op[EXP_W+MAN_W-1:MAN_W];
    assign b_exp = b_op[EXP_W+MAN_W-1:MAN_W];
    assign a_sig = {a_hid, a_op[MAN_W-1:0]};
    assign b_sig = {b_hid, b_op[MAN_W-1:0]};
    assign d = {1'b0, a_exp} - {1'b0, b_exp};
    assign mag = d[EXP_W] ? -d : d;
    assign sh = (32'(mag) > W) ? SH_W'(W) : SH_W'(mag);
    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_v_q || s2_ready;
    assign s1_ld = in_valid && in_ready;
    assign s2_ld = s1_v_q && s2_ready;

`ifdef FP_ALIGN_STICKY_EN
    logic [2*W-1:0] wide;
    // the lower half of the double-width shift collects every bit pushed out of small_man
    assign wide = {s1_small_q, {(GRD_W + W){1'b0}}} >> s1_sh_q;
    assign stk = |wide[W-1:0];
    assign shifted = wide[2*W-1:W] | {{(W - 1){1'b0}}, stk};
`else
    assign stk = 1'b0;
    assign shifted = {s1_small_q, {GRD_W{1'b0}}} >> s1_sh_q;
`endif

    // next state: valids follow the handshake, data reloads only on a transfer into the stage
    always_comb begin
        s1_v_d      = in_ready ? in_valid : s1_v_q;
        s1_swp_d    = s1_ld ? d[EXP_W] : s1_swp_q;
        s1_big_d    = s1_ld ? (d[EXP_W] ? b_sig : a_sig) : s1_big_q;
        s1_small_d  = s1_ld ? (d[EXP_W] ? a_sig : b_sig) : s1_small_q;
        s1_exp_d    = s1_ld ? (d[EXP_W] ? b_exp : a_exp) : s1_exp_q;
        s1_sh_d     = s1_ld ? sh : s1_sh_q;
        out_valid_d = s2_ready ? s1_v_q : out_valid_q;
        swapped_d   = s2_ld ? s1_swp_q : swapped_q;
        big_man_d   = s2_ld ? {s1_big_q, {GRD_W{1'b0}}} : big_man_q;
        small_man_d = s2_ld ? shifted : small_man_q;
        big_exp_d   = s2_ld ? s1_exp_q : big_exp_q;
        sticky_d    = s2_ld ? stk : sticky_q;
    end

    // pipeline registers; reset drops anything in flight at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s1_swp_q    <= 1'b0;
            s1_big_q    <= '0;
            s1_small_q  <= '0;
            s1_exp_q    <= '0;
            s1_sh_q     <= '0;
            out_valid_q <= 1'b0;
            swapped_q   <= 1'b0;
            big_man_q   <= '0;
            small_man_q <= '0;
            big_exp_q   <= '0;
            sticky_q    <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_swp_q    <= s1_swp_d;
            s1_big_q    <= s1_big_d;
            s1_small_q  <= s1_small_d;
            s1_exp_q    <= s1_exp_d;
            s1_sh_q     <= s1_sh_d;
            out_valid_q <= out_valid_d;
            swapped_q   <= swapped_d;
            big_man_q   <= big_man_d;
            small_man_q <= small_man_d;
            big_exp_q   <= big_exp_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid = out_valid_q;
    assign big_man   = big_man_q;
    assign small_man = small_man_q;
    assign big_exp   = big_exp_q;
    assign swapped   = swapped_q;
    assign sticky    = sticky_q;
endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe: scoreboard model plus directed literal checks for fp_align_pipe
module tb_fp_align_pipe;
    typedef struct packed {
        logic [32:0] bm;
        logic [32:0] sm;
        logic [7:0]  be;
        logic        sw;
        logic        st;
    } res_t;

`ifdef FP_ALIGN_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic clk, reset, in_valid, in_ready, a_hid, b_hid, out_valid, out_ready, swapped, sticky;
    logic [30:0] a_op, b_op;
    logic [32:0] big_man, small_man;
    logic [7:0] big_exp;
    int checks = 0;
    int errors = 0;
    int n_out = 0;
    res_t q[$];

    fp_align_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_op(a_op), .b_op(b_op), .a_hid(a_hid), .b_hid(b_hid),
        .out_valid(out_valid), .out_ready(out_ready), .big_man(big_man),
        .small_man(small_man), .big_exp(big_exp), .swapped(swapped), .sticky(sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [30:0] a, input logic ah, input logic [30:0] b, input logic bh);
        res_t r;
        int ea, eb, sh;
        longint unsigned bs, ss, v, sm;
        logic st;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        r.sw = eb > ea;
        bs = r.sw ? 64'({bh, b[22:0]}) : 64'({ah, a[22:0]});
        ss = r.sw ? 64'({ah, a[22:0]}) : 64'({bh, b[22:0]});
        sh = r.sw ? eb - ea : ea - eb;
        if (sh > 33) sh = 33;
        v = ss << 9;
        sm = v >> sh;
        r.bm = 33'(bs << 9);
        r.be = 8'(r.sw ? eb : ea);
`ifdef FP_ALIGN_STICKY_EN
        st = (v & ((64'd1 << sh) - 64'd1)) != 64'd0;
        r.st = st;
        r.sm = 33'(sm) | 33'(st);
`else
        st = 1'b0;
        r.st = st;
        r.sm = 33'(sm);
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic [32:0] bm, input logic [32:0] sm,
                              input logic [7:0] be, input logic sw, input logic st);
        chk({nm, "_big_man"}, 64'(big_man), 64'(bm));
        chk({nm, "_small_man"}, 64'(small_man), 64'(sm));
        chk({nm, "_big_exp"}, 64'(big_exp), 64'(be));
        chk({nm, "_swapped"}, 64'(swapped), 64'(sw));
        chk({nm, "_sticky"}, 64'(sticky), 64'(st));
    endtask

    task automatic drive(input logic [7:0] ea, input logic [22:0] fa, input logic ha,
                         input logic [7:0] eb, input logic [22:0] fb, input logic hb);
        a_op = {ea, fa};
        a_hid = ha;
        b_op = {eb, fb};
        b_hid = hb;
    endtask

    task automatic drive_pair(input int k);
        drive(8'(32'h80 + k), 23'(k * 32'h1357), 1'b1,
              8'(32'h7C + (k * 7) % 13), 23'(32'h7FFFFF - k * 32'h2468), k[0]);
    endtask

    // single pair into an idle pipeline; returns at the negedge where the result must be visible
    task automatic send_one(input string nm, input logic [7:0] ea, input logic [22:0] fa, input logic ha,
                            input logic [7:0] eb, input logic [22:0] fb, input logic hb);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        drive(ea, fa, ha, eb, fb, hb);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({nm, "_accept_timeout"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_lat2_valid"}, 64'(out_valid), 64'd1);
    endtask

    // scoreboard: compare every valid output, retire on handshake, enqueue on input handshake
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid got %b want 0", out_valid);
            end
        end else begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_output got bm=%h sm=%h be=%h sw=%b st=%b want none",
                             big_man, small_man, big_exp, swapped, sticky);
                end else if ({big_man, small_man, big_exp, swapped, sticky} !== q[0]) begin
                    errors++;
                    $display("FAIL stream_result got bm=%h sm=%h be=%h sw=%b st=%b want bm=%h sm=%h be=%h sw=%b st=%b",
                             big_man, small_man, big_exp, swapped, sticky,
                             q[0].bm, q[0].sm, q[0].be, q[0].sw, q[0].st);
                end
                if (out_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a_op, a_hid, b_op, b_hid));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base;
        logic acc;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(8'h0, 23'h0, 1'b0, 8'h0, 23'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        expect_out("rst", 33'h0, 33'h0, 8'h0, 1'b0, 1'b0);

        send_one("basic", 8'h85, 23'h0, 1'b1, 8'h80, 23'h0, 1'b1);
        expect_out("basic", 33'h1_0000_0000, 33'h0_0800_0000, 8'h85, 1'b0, 1'b0);

        send_one("swap", 8'h80, 23'h0, 1'b1, 8'h85, 23'h123456, 1'b1);
        expect_out("swap", 33'h1_2468_AC00, 33'h0_0800_0000, 8'h85, 1'b1, 1'b0);

        send_one("sat", 8'hAD, 23'h0, 1'b1, 8'h10, 23'h0, 1'b1);
        expect_out("sat", 33'h1_0000_0000, 33'(STK), 8'hAD, 1'b0, STK);

        send_one("stk10", 8'h8A, 23'h0, 1'b1, 8'h80, 23'h000001, 1'b1);
        expect_out("stk10", 33'h1_0000_0000, 33'h0_0040_0000 | 33'(STK), 8'h8A, 1'b0, STK);

        send_one("stk9", 8'h89, 23'h0, 1'b1, 8'h80, 23'h000001, 1'b1);
        expect_out("stk9", 33'h1_0000_0000, 33'h0_0080_0001, 8'h89, 1'b0, 1'b0);

        send_one("equal", 8'h40, 23'h000F00, 1'b1, 8'h40, 23'h7FFFFF, 1'b0);
        expect_out("equal", 33'h1_001E_0000, 33'h0_FFFF_FE00, 8'h40, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        base = n_out;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            drive_pair(k);
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        chk("bp_accepted", 64'(k), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive_pair(k);
            @(negedge clk);
            chk("tput_in_ready", 64'(in_ready), 64'd1);
            chk("tput_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("bp_out_count", 64'(n_out - base), 64'd10);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive_pair(20);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive_pair(21);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_valid", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(out_valid), 64'd0);
        end
        send_one("recover", 8'h85, 23'h0, 1'b1, 8'h80, 23'h0, 1'b1);
        expect_out("recover", 33'h1_0000_0000, 33'h0_0800_0000, 8'h85, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
